// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the countdown timer.
// COUNTDOWN_BCD_EN selects decimal digits (wrap 0 -> 9) instead of binary (wrap 0 -> 15).
package countdown_timer_pkg;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam int             DIGIT_W       = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX_BIN = 4'd15;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX_BCD = 4'd9;

`ifdef COUNTDOWN_BCD_EN
    localparam logic [DIGIT_W-1:0] DIGIT_WRAP = DIGIT_MAX_BCD;
`else
    localparam logic [DIGIT_W-1:0] DIGIT_WRAP = DIGIT_MAX_BIN;
`endif
endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle of the countdown timer; master drives controls, slave is the timer.
interface countdown_timer_if #(parameter int DIGITS = 2);
    logic                  LDBar;
    logic [4*DIGITS-1:0]   D;
    logic                  START;
    logic                  STOP;
    logic                  PAUSE;
    logic                  AR;
    logic [4*DIGITS-1:0]   Q;
    logic                  ZERO;
    logic                  DONE;
    logic                  BUSY;

    modport master (output LDBar, D, START, STOP, PAUSE, AR,
                    input  Q, ZERO, DONE, BUSY);
    modport slave  (input  LDBar, D, START, STOP, PAUSE, AR,
                    output Q, ZERO, DONE, BUSY);
endinterface

// File: rtl/countdown_timer_down_counter4.sv
// One 4-bit down-counter digit: sync clear, active-low load, enabled decrement with wrap.
// Wrap value comes from the package (binary or BCD via COUNTDOWN_BCD_EN).
module down_counter4
    import countdown_timer_pkg::*;
(
    input  logic               i_CP,
    input  logic               i_CR,
    input  logic               i_LDBar,
    input  logic               i_EN,
    input  logic [DIGIT_W-1:0] i_D,
    output logic [DIGIT_W-1:0] o_Q,
    output logic               o_BO
);
    logic [DIGIT_W-1:0] r_q;

    always_ff @(posedge i_CP) begin
        if (i_CR)          r_q <= '0;
        else if (!i_LDBar) r_q <= i_D;
        else if (i_EN)     r_q <= (r_q == '0) ? DIGIT_WRAP : r_q - 4'd1;
    end

    assign o_Q  = r_q;
    assign o_BO = (r_q == '0) & i_EN;
endmodule

// File: rtl/countdown_timer.sv
// Loadable, pausable multi-digit countdown timer with one-cycle DONE and optional auto-reload.
// Digit wrap behaviour follows COUNTDOWN_BCD_EN (see package).
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic               i_CP,
    input  logic               i_CR,
    countdown_timer_if.slave   bus
);
    localparam int W = DIGIT_W * DIGITS;

    state_t            r_state;
    logic              r_done;
    logic [W-1:0]      w_q;
    logic              w_zero;
    logic              w_cnt_ok;
    logic              w_run_act;
    logic              w_reload;
    logic              w_ld_n;
    logic [DIGITS-1:0] w_en;
    logic [DIGITS-1:0] w_bo;
    logic              w_unused_bo;

    assign w_zero    = (w_q == '0);
    // Counting is allowed only when no higher-priority action (load/stop/pause) claims the edge.
    assign w_cnt_ok  = (r_state == RUN) & bus.LDBar & ~bus.STOP & ~bus.PAUSE;
    assign w_run_act = w_cnt_ok & ~w_zero;
    assign w_reload  = w_cnt_ok & w_zero;
    assign w_ld_n    = bus.LDBar & ~w_reload;
    assign w_en[0]   = w_run_act;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            down_counter4 u_digit (
                .i_CP    (i_CP),
                .i_CR    (i_CR),
                .i_LDBar (w_ld_n),
                .i_EN    (w_en[g]),
                .i_D     (bus.D[g*DIGIT_W +: DIGIT_W]),
                .o_Q     (w_q[g*DIGIT_W +: DIGIT_W]),
                .o_BO    (w_bo[g])
            );
            if (g > 0) begin : g_chain
                assign w_en[g] = w_bo[g-1];
            end
        end
    endgenerate

    // The top digit's borrow has nowhere to go: Q never underflows while counting.
    assign w_unused_bo = w_bo[DIGITS-1];

    always_ff @(posedge i_CP) begin
        if (i_CR) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.LDBar) begin
                unique case (r_state)
                    IDLE: if (bus.START) begin
                        if (!w_zero) r_state <= RUN;
                        else         r_done  <= 1'b1;
                    end
                    RUN: if (bus.STOP) begin
                        r_state <= IDLE;
                    end else if (!bus.PAUSE) begin
                        if (!w_zero) begin
                            if (w_q == W'(1)) begin
                                r_done <= 1'b1;
                                if (!bus.AR) r_state <= IDLE;
                            end
                        end else if (bus.D == '0) begin
                            r_state <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.Q    = w_q;
    assign bus.ZERO = w_zero;
    assign bus.DONE = r_done;
    assign bus.BUSY = (r_state == RUN);
endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer (DIGITS=2).
module tb_countdown_timer;
    logic clk = 1'b0;
    logic cr  = 1'b0;
    int   checks = 0;
    int   failures = 0;

    countdown_timer_if #(.DIGITS(2)) bus ();

    countdown_timer #(.DIGITS(2)) dut (
        .i_CP (clk),
        .i_CR (cr),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] d);
        bus.D = d; bus.LDBar = 1'b0;
        step();
        bus.LDBar = 1'b1;
    endtask

    task automatic test_reset();
        cr = 1'b1; step(); cr = 1'b0;
        checks++; if (bus.Q !== 8'h00) begin failures++; $display("FAIL reset_q got=%h exp=00", bus.Q); end
        checks++; if (bus.DONE !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.DONE); end
        checks++; if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.BUSY); end
        checks++; if (bus.ZERO !== 1'b1) begin failures++; $display("FAIL reset_zero got=%b exp=1", bus.ZERO); end
        bus.START = 1'b1; step(); bus.START = 1'b0;
        checks++; if (bus.DONE !== 1'b1) begin failures++; $display("FAIL start_zero_done got=%b exp=1", bus.DONE); end
        checks++; if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL start_zero_busy got=%b exp=0", bus.BUSY); end
        step();
        checks++; if (bus.DONE !== 1'b0) begin failures++; $display("FAIL start_zero_done_end got=%b exp=0", bus.DONE); end
    endtask

    task automatic test_one_shot();
        logic [7:0] exp_q [5] = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
        load(8'h05);
        checks++; if (bus.Q !== 8'h05 || bus.BUSY !== 1'b0) begin failures++; $display("FAIL os_load q=%h busy=%b exp q=05 busy=0", bus.Q, bus.BUSY); end
        bus.START = 1'b1; step(); bus.START = 1'b0;
        checks++; if (bus.Q !== 8'h05 || bus.BUSY !== 1'b1) begin failures++; $display("FAIL os_start q=%h busy=%b exp q=05 busy=1", bus.Q, bus.BUSY); end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (bus.Q !== exp_q[i] || bus.DONE !== (exp_q[i] == 8'h00) ||
                bus.BUSY !== (exp_q[i] != 8'h00) || bus.ZERO !== (exp_q[i] == 8'h00)) begin
                failures++;
                $display("FAIL os_step%0d q=%h done=%b busy=%b zero=%b exp q=%h", i, bus.Q, bus.DONE, bus.BUSY, bus.ZERO, exp_q[i]);
            end
        end
        step();
        checks++; if (bus.DONE !== 1'b0 || bus.Q !== 8'h00) begin failures++; $display("FAIL os_after done=%b q=%h exp done=0 q=00", bus.DONE, bus.Q); end
    endtask

    task automatic test_borrow();
        logic [7:0] exp;
`ifdef COUNTDOWN_BCD_EN
        exp = 8'h09;
`else
        exp = 8'h0F;
`endif
        load(8'h10);
        bus.START = 1'b1; step(); bus.START = 1'b0;
        step();
        checks++; if (bus.Q !== exp) begin failures++; $display("FAIL borrow got=%h exp=%h", bus.Q, exp); end
        bus.STOP = 1'b1; step(); bus.STOP = 1'b0;
        checks++; if (bus.BUSY !== 1'b0 || bus.Q !== exp) begin failures++; $display("FAIL borrow_stop busy=%b q=%h exp busy=0 q=%h", bus.BUSY, bus.Q, exp); end
    endtask

    task automatic test_pause_stop();
        load(8'h08);
        bus.START = 1'b1; step(); bus.START = 1'b0;
        step(); step();
        checks++; if (bus.Q !== 8'h06) begin failures++; $display("FAIL ps_pre got=%h exp=06", bus.Q); end
        bus.PAUSE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.Q !== 8'h06 || bus.BUSY !== 1'b1) begin failures++; $display("FAIL ps_hold%0d q=%h busy=%b exp q=06 busy=1", i, bus.Q, bus.BUSY); end
        end
        bus.PAUSE = 1'b0;
        step(); step();
        checks++; if (bus.Q !== 8'h04) begin failures++; $display("FAIL ps_resume got=%h exp=04", bus.Q); end
        bus.STOP = 1'b1; step(); bus.STOP = 1'b0;
        checks++; if (bus.Q !== 8'h04 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
            failures++; $display("FAIL ps_stop q=%h busy=%b done=%b exp q=04 busy=0 done=0", bus.Q, bus.BUSY, bus.DONE);
        end
        step();
        checks++; if (bus.Q !== 8'h04 || bus.DONE !== 1'b0) begin failures++; $display("FAIL ps_idle q=%h done=%b exp q=04 done=0", bus.Q, bus.DONE); end
    endtask

    task automatic test_auto_reload();
        logic [7:0] exp_q [6] = '{8'h01, 8'h00, 8'h02, 8'h01, 8'h00, 8'h02};
        logic       exp_d [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        bus.AR = 1'b1;
        load(8'h02);
        bus.START = 1'b1; step(); bus.START = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (bus.Q !== exp_q[i] || bus.DONE !== exp_d[i] || bus.BUSY !== 1'b1) begin
                failures++;
                $display("FAIL ar_step%0d q=%h done=%b busy=%b exp q=%h done=%b busy=1", i, bus.Q, bus.DONE, bus.BUSY, exp_q[i], exp_d[i]);
            end
        end
        load(8'h00);
        checks++; if (bus.Q !== 8'h00 || bus.BUSY !== 1'b1 || bus.DONE !== 1'b0) begin
            failures++; $display("FAIL ar_load0 q=%h busy=%b done=%b exp q=00 busy=1 done=0", bus.Q, bus.BUSY, bus.DONE);
        end
        step();
        checks++; if (bus.Q !== 8'h00 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
            failures++; $display("FAIL ar_stop q=%h busy=%b done=%b exp q=00 busy=0 done=0", bus.Q, bus.BUSY, bus.DONE);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) begin failures++; $display("FAIL ar_quiet%0d done=%b busy=%b exp 0 0", i, bus.DONE, bus.BUSY); end
        end
        bus.AR = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        load(8'h09);
        bus.START = 1'b1; step(); bus.START = 1'b0;
        step(); step();
        checks++; if (bus.Q !== 8'h07 || bus.BUSY !== 1'b1) begin failures++; $display("FAIL rm_pre q=%h busy=%b exp q=07 busy=1", bus.Q, bus.BUSY); end
        cr = 1'b1; step(); cr = 1'b0;
        checks++; if (bus.Q !== 8'h00 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
            failures++; $display("FAIL rm_reset q=%h busy=%b done=%b exp q=00 busy=0 done=0", bus.Q, bus.BUSY, bus.DONE);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0 || bus.Q !== 8'h00) begin
                failures++; $display("FAIL rm_after%0d q=%h busy=%b done=%b exp q=00 0 0", i, bus.Q, bus.BUSY, bus.DONE);
            end
        end
    endtask

    initial begin
        bus.LDBar = 1'b1; bus.D = 8'h00; bus.START = 1'b0;
        bus.STOP = 1'b0; bus.PAUSE = 1'b0; bus.AR = 1'b0;
        test_reset();
        test_one_shot();
        test_borrow();
        test_pause_stop();
        test_auto_reload();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
